// File: rtl/mac_accumulator.sv
// ============================================================================
// Module   : mac_accumulator (with array_multiplier)
// Brief    : Handshaked 4x4 multiply-accumulate stage that sums CNT products
//            into one dot-product result with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_multiplier (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [7:0] w_pp [4];

    // One shifted partial-product row per multiplier bit.
    for (genvar i = 0; i < 4; i++) begin : g_pp
        assign w_pp[i] = 8'({4'b0000, i_a & {4{i_b[i]}}} << i);
    end

    assign o_p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];
endmodule

module mac_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam logic [7:0] c_cnt  = 8'(CNT);
    localparam logic [7:0] c_last = 8'(CNT - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op_a;
    logic [3:0]       r_op_b;
    logic             r_op_vld;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_taken;
    logic [7:0]       r_done_cnt;
    logic [7:0]       w_prod;
    logic [ACC_W:0]   w_sum;
    logic             w_in_fire;
    logic             w_out_fire;

    array_multiplier u_mult (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_p (w_prod)
    );

    // Extra top bit of the sum is the carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_prod);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_sum     = '0;
        out_ovf     = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = (r_taken < c_cnt);
                if (r_op_vld && (r_done_cnt == c_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_sum   = r_acc;
                out_ovf   = r_ovf;
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
        w_in_fire  = in_valid && in_ready;
        w_out_fire = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ACC;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_vld   <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_taken    <= '0;
            r_done_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op_vld <= w_in_fire;
            if (w_in_fire) begin
                r_op_a  <= a;
                r_op_b  <= b;
                r_taken <= r_taken + 8'd1;
            end
            if (r_op_vld) begin
                r_acc      <= w_sum[ACC_W-1:0];
                r_ovf      <= r_ovf | w_sum[ACC_W];
                r_done_cnt <= r_done_cnt + 8'd1;
            end
            // Accumulate and result transfer never coincide: op_vld is
            // always clear while a result is held.
            if (w_out_fire) begin
                r_acc      <= '0;
                r_ovf      <= 1'b0;
                r_taken    <= '0;
                r_done_cnt <= '0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
// Module   : tb_mac_accumulator
// Brief    : Directed self-checking bench for mac_accumulator in three
//            parameterisations (default, ACC_W=9, CNT=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accumulator;
    logic clk;
    logic rst;

    logic        d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_out_ovf;
    logic [3:0]  d0_a, d0_b;
    logic [15:0] d0_out_sum;

    logic        d9_in_valid, d9_in_ready, d9_out_valid, d9_out_ready, d9_out_ovf;
    logic [3:0]  d9_a, d9_b;
    logic [8:0]  d9_out_sum;

    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_out_ovf;
    logic [3:0]  d1_a, d1_b;
    logic [15:0] d1_out_sum;

    int n_vec = 0;
    int n_err = 0;

    mac_accumulator u_d0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .a(d0_a), .b(d0_b), .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .out_sum(d0_out_sum), .out_ovf(d0_out_ovf)
    );

    mac_accumulator #(.ACC_W(9), .CNT(4)) u_d9 (
        .clk(clk), .rst(rst), .in_valid(d9_in_valid), .in_ready(d9_in_ready),
        .a(d9_a), .b(d9_b), .out_valid(d9_out_valid), .out_ready(d9_out_ready),
        .out_sum(d9_out_sum), .out_ovf(d9_out_ovf)
    );

    mac_accumulator #(.ACC_W(16), .CNT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_sum(d1_out_sum), .out_ovf(d1_out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++; if (d0_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0d expected 0", d0_out_valid); end
        n_vec++; if (d0_out_sum !== 16'd0) begin n_err++; $display("FAIL rst_out_sum: got %0d expected 0", d0_out_sum); end
        n_vec++; if (d0_out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_out_ovf: got %0d expected 0", d0_out_ovf); end
        n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0d expected 1", d0_in_ready); end
        n_vec++; if (d9_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_w9: got %0d expected 1", d9_in_ready); end
        n_vec++; if (d1_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_c1: got %0d expected 1", d1_in_ready); end
    endtask

    task automatic test_back_to_back();
        int ta[4] = '{3, 7, 15, 0};
        int tb[4] = '{5, 2, 15, 9};
        d0_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0_in_valid = 1'b1; d0_a = 4'(ta[i]); d0_b = 4'(tb[i]);
            n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %0d expected 1", i, d0_in_ready); end
            tick();
        end
        d0_in_valid = 1'b0;
        n_vec++; if (d0_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early_valid: got %0d expected 0", d0_out_valid); end
        n_vec++; if (d0_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %0d expected 0", d0_in_ready); end
        tick();
        n_vec++; if (d0_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %0d expected 1", d0_out_valid); end
        n_vec++; if (d0_out_sum !== 16'd254) begin n_err++; $display("FAIL b2b_sum: got %0d expected 254", d0_out_sum); end
        n_vec++; if (d0_out_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %0d expected 0", d0_out_ovf); end
        tick();
        n_vec++; if (d0_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %0d expected 0", d0_out_valid); end
        n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %0d expected 1", d0_in_ready); end
    endtask

    task automatic test_gaps();
        int ta[4] = '{3, 7, 15, 0};
        int tb[4] = '{5, 2, 15, 9};
        int gp[3] = '{1, 3, 2};
        int k;
        d0_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0_in_valid = 1'b1; d0_a = 4'(ta[i]); d0_b = 4'(tb[i]);
            n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL gap_in_ready[%0d]: got %0d expected 1", i, d0_in_ready); end
            tick();
            d0_in_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gp[i]; g++) begin
                    n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL gap_idle_ready[%0d]: got %0d expected 1", i, d0_in_ready); end
                    tick();
                end
            end
        end
        k = 0;
        while (d0_out_valid !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (d0_out_valid !== 1'b1) begin n_err++; $display("FAIL gap_timeout: got %0d expected 1", d0_out_valid); end
        n_vec++; if (d0_out_sum !== 16'd254) begin n_err++; $display("FAIL gap_sum: got %0d expected 254", d0_out_sum); end
        n_vec++; if (d0_out_ovf !== 1'b0) begin n_err++; $display("FAIL gap_ovf: got %0d expected 0", d0_out_ovf); end
        tick();
    endtask

    task automatic test_backpressure();
        int k;
        d0_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d0_in_valid = 1'b1; d0_a = 4'd1; d0_b = 4'd2;
            tick();
        end
        d0_a = 4'd15; d0_b = 4'd15;
        k = 0;
        while (d0_out_valid !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (d0_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got %0d expected 1", d0_out_valid); end
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (d0_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %0d expected 1", c, d0_out_valid); end
            n_vec++; if (d0_out_sum !== 16'd8) begin n_err++; $display("FAIL bp_hold_sum[%0d]: got %0d expected 8", c, d0_out_sum); end
            n_vec++; if (d0_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready[%0d]: got %0d expected 0", c, d0_in_ready); end
            tick();
        end
        // in_valid stays high with 15x15 through the release edge.
        d0_out_ready = 1'b1;
        tick();
        n_vec++; if (d0_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0d expected 0", d0_out_valid); end
        n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0d expected 1", d0_in_ready); end
        for (int i = 0; i < 4; i++) tick();
        d0_in_valid = 1'b0;
        k = 0;
        while (d0_out_valid !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (d0_out_sum !== 16'd900) begin n_err++; $display("FAIL bp_next_sum: got %0d expected 900", d0_out_sum); end
        n_vec++; if (d0_out_ovf !== 1'b0) begin n_err++; $display("FAIL bp_next_ovf: got %0d expected 0", d0_out_ovf); end
        tick();
    endtask

    task automatic test_overflow();
        int k;
        d9_out_ready = 1'b1;
        d9_in_valid = 1'b1; d9_a = 4'd15; d9_b = 4'd15;
        for (int i = 0; i < 4; i++) tick();
        d9_in_valid = 1'b0;
        k = 0;
        while (d9_out_valid !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (d9_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_timeout: got %0d expected 1", d9_out_valid); end
        n_vec++; if (d9_out_sum !== 9'd388) begin n_err++; $display("FAIL ovf_sum: got %0d expected 388", d9_out_sum); end
        n_vec++; if (d9_out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0d expected 1", d9_out_ovf); end
        tick();
        d9_in_valid = 1'b1; d9_a = 4'd1; d9_b = 4'd1;
        for (int i = 0; i < 4; i++) tick();
        d9_in_valid = 1'b0;
        k = 0;
        while (d9_out_valid !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (d9_out_sum !== 9'd4) begin n_err++; $display("FAIL ovf_next_sum: got %0d expected 4", d9_out_sum); end
        n_vec++; if (d9_out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_next_flag: got %0d expected 0", d9_out_ovf); end
        tick();
    endtask

    task automatic test_mid_reset();
        int k;
        d0_out_ready = 1'b1;
        d0_in_valid = 1'b1; d0_a = 4'd9; d0_b = 4'd9;
        tick();
        tick();
        d0_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (d0_out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %0d expected 0", d0_out_valid); end
        n_vec++; if (d0_in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %0d expected 1", d0_in_ready); end
        d0_in_valid = 1'b1; d0_a = 4'd1; d0_b = 4'd1;
        for (int i = 0; i < 4; i++) tick();
        d0_in_valid = 1'b0;
        k = 0;
        while (d0_out_valid !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (d0_out_valid !== 1'b1) begin n_err++; $display("FAIL mrst_timeout: got %0d expected 1", d0_out_valid); end
        n_vec++; if (d0_out_sum !== 16'd4) begin n_err++; $display("FAIL mrst_sum: got %0d expected 4", d0_out_sum); end
        tick();
    endtask

    task automatic test_cnt_one();
        int ta[3] = '{12, 0, 15};
        int tb[3] = '{13, 0, 1};
        int ex[3] = '{156, 0, 15};
        d1_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d1_in_valid = 1'b1; d1_a = 4'(ta[i]); d1_b = 4'(tb[i]);
            n_vec++; if (d1_in_ready !== 1'b1) begin n_err++; $display("FAIL c1_ready[%0d]: got %0d expected 1", i, d1_in_ready); end
            tick();
            d1_in_valid = 1'b0;
            n_vec++; if (d1_out_valid !== 1'b0) begin n_err++; $display("FAIL c1_early[%0d]: got %0d expected 0", i, d1_out_valid); end
            tick();
            n_vec++; if (d1_out_valid !== 1'b1) begin n_err++; $display("FAIL c1_valid[%0d]: got %0d expected 1", i, d1_out_valid); end
            n_vec++; if (d1_out_sum !== 16'(ex[i])) begin n_err++; $display("FAIL c1_sum[%0d]: got %0d expected %0d", i, d1_out_sum, ex[i]); end
            n_vec++; if (d1_out_ovf !== 1'b0) begin n_err++; $display("FAIL c1_ovf[%0d]: got %0d expected 0", i, d1_out_ovf); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        d0_in_valid = 1'b0; d0_a = '0; d0_b = '0; d0_out_ready = 1'b0;
        d9_in_valid = 1'b0; d9_a = '0; d9_b = '0; d9_out_ready = 1'b0;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_cnt_one();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
